// File: rtl/wb_sram_port0_ctrl.sv
// Port-0 controller for the sky130 1 KiB SRAM macro: Wishbone classic slave plus an optional
// round-robin auxiliary requester (enable with macro SRAM_CTRL_AUX_EN).
module wb_sram_port0_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          WIN_BITS  = 10,
    parameter int          READ_LAT  = 1
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic        aux_req,
    input  logic        aux_we,
    input  logic [7:0]  aux_addr,
    input  logic [31:0] aux_wdata,
    input  logic [3:0]  aux_wmask,
    output logic        aux_gnt,
    output logic        aux_rvalid,
    output logic [31:0] aux_rdata,
    output logic        sram_csb0,
    output logic        sram_web0,
    output logic [3:0]  sram_wmask0,
    output logic [7:0]  sram_addr0,
    output logic [31:0] sram_din0,
    input  logic [31:0] sram_dout0,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_ACK   = 3'd3,
        S_MISS  = 3'd4
    } state_t;

    state_t      r_state, w_state_nx;
    logic [1:0]  r_cnt, w_cnt_nx;
    logic        r_csb, w_csb_nx;
    logic        r_web, w_web_nx;
    logic [3:0]  r_wmask, w_wmask_nx;
    logic [7:0]  r_addr, w_addr_nx;
    logic [31:0] r_din, w_din_nx;
    logic        r_ack, w_ack_nx;
    logic [31:0] r_dat, w_dat_nx;
    logic        r_busy, w_busy_nx;

    logic        w_hit;
    logic        w_wb_req;
    logic        w_wb_miss;
    logic        w_pick_aux;
    logic        w_owner_aux;
    logic        w_unused_adr;

    assign w_hit     = (wbs_adr_i[31:WIN_BITS] == BASE_ADDR[31:WIN_BITS]);
    assign w_wb_req  = wbs_cyc_i & wbs_stb_i & w_hit;
    assign w_wb_miss = wbs_cyc_i & wbs_stb_i & ~w_hit;
    assign w_unused_adr = ^wbs_adr_i[1:0];

`ifdef SRAM_CTRL_AUX_EN
    // Aux handshake: aux_req with its payload is held until the single-cycle aux_gnt;
    // read data arrives later with the single-cycle aux_rvalid, writes get no response.
    logic        r_gnt, w_gnt_nx;
    logic        r_rvalid, w_rvalid_nx;
    logic [31:0] r_rdata, w_rdata_nx;
    logic        r_owner_aux, w_owner_aux_nx;
    logic        r_last_aux, w_last_aux_nx;

    // On a tie the grant goes to whichever side did not own the previous access.
    assign w_pick_aux  = aux_req & (~w_wb_req | ~r_last_aux);
    assign w_owner_aux = r_owner_aux;
    assign aux_gnt     = r_gnt;
    assign aux_rvalid  = r_rvalid;
    assign aux_rdata   = r_rdata;
`else
    logic w_unused_aux;
    assign w_unused_aux = ^{aux_req, aux_we, aux_addr, aux_wdata, aux_wmask};
    assign w_pick_aux   = 1'b0;
    assign w_owner_aux  = 1'b0;
    assign aux_gnt      = 1'b0;
    assign aux_rvalid   = 1'b0;
    assign aux_rdata    = 32'h0;
`endif

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_csb_nx   = r_csb;
        w_web_nx   = r_web;
        w_wmask_nx = r_wmask;
        w_addr_nx  = r_addr;
        w_din_nx   = r_din;
        w_ack_nx   = 1'b0;
        w_dat_nx   = r_dat;
`ifdef SRAM_CTRL_AUX_EN
        w_gnt_nx       = 1'b0;
        w_rvalid_nx    = 1'b0;
        w_rdata_nx     = r_rdata;
        w_owner_aux_nx = r_owner_aux;
        w_last_aux_nx  = r_last_aux;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_pick_aux) begin
                    w_csb_nx   = 1'b0;
                    w_state_nx = S_ISSUE;
`ifdef SRAM_CTRL_AUX_EN
                    w_web_nx       = ~aux_we;
                    w_addr_nx      = aux_addr;
                    w_din_nx       = aux_wdata;
                    w_wmask_nx     = aux_wmask;
                    w_gnt_nx       = 1'b1;
                    w_owner_aux_nx = 1'b1;
                    w_last_aux_nx  = 1'b1;
`endif
                end else if (w_wb_req) begin
                    w_csb_nx   = 1'b0;
                    w_web_nx   = ~wbs_we_i;
                    w_addr_nx  = wbs_adr_i[9:2];
                    w_din_nx   = wbs_dat_i;
                    w_wmask_nx = wbs_sel_i;
                    w_state_nx = S_ISSUE;
`ifdef SRAM_CTRL_AUX_EN
                    w_owner_aux_nx = 1'b0;
                    w_last_aux_nx  = 1'b0;
`endif
                end else if (w_wb_miss) begin
                    w_ack_nx   = 1'b1;
                    w_dat_nx   = 32'h0;
                    w_state_nx = S_MISS;
                end
            end
            S_ISSUE: begin
                // The macro samples csb0/web0 on this edge; release them so the strobe is one cycle.
                w_csb_nx = 1'b1;
                w_web_nx = 1'b1;
                if (!r_web) begin
                    w_state_nx = S_ACK;
                    if (!w_owner_aux) w_ack_nx = wbs_cyc_i;
                end else begin
                    w_state_nx = S_WAIT;
                    w_cnt_nx   = 2'(READ_LAT);
                end
            end
            S_WAIT: begin
                w_cnt_nx = r_cnt - 2'd1;
                if (r_cnt == 2'd1) begin
                    w_state_nx = S_ACK;
                    if (w_owner_aux) begin
`ifdef SRAM_CTRL_AUX_EN
                        w_rvalid_nx = 1'b1;
                        w_rdata_nx  = sram_dout0;
`endif
                    end else begin
                        // A dropped cyc still lets the access finish, only the ack is withheld.
                        w_dat_nx = sram_dout0;
                        w_ack_nx = wbs_cyc_i;
                    end
                end
            end
            S_ACK:   w_state_nx = S_IDLE;
            S_MISS:  w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
        w_busy_nx = (w_state_nx != S_IDLE);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= 2'd0;
            r_csb   <= 1'b1;
            r_web   <= 1'b1;
            r_wmask <= 4'h0;
            r_addr  <= 8'h0;
            r_din   <= 32'h0;
            r_ack   <= 1'b0;
            r_dat   <= 32'h0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_csb   <= w_csb_nx;
            r_web   <= w_web_nx;
            r_wmask <= w_wmask_nx;
            r_addr  <= w_addr_nx;
            r_din   <= w_din_nx;
            r_ack   <= w_ack_nx;
            r_dat   <= w_dat_nx;
            r_busy  <= w_busy_nx;
        end
    end

`ifdef SRAM_CTRL_AUX_EN
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_gnt       <= 1'b0;
            r_rvalid    <= 1'b0;
            r_rdata     <= 32'h0;
            r_owner_aux <= 1'b0;
            r_last_aux  <= 1'b1;
        end else begin
            r_gnt       <= w_gnt_nx;
            r_rvalid    <= w_rvalid_nx;
            r_rdata     <= w_rdata_nx;
            r_owner_aux <= w_owner_aux_nx;
            r_last_aux  <= w_last_aux_nx;
        end
    end
`endif

    assign wbs_ack_o   = r_ack;
    assign wbs_dat_o   = r_dat;
    assign sram_csb0   = r_csb;
    assign sram_web0   = r_web;
    assign sram_wmask0 = r_wmask;
    assign sram_addr0  = r_addr;
    assign sram_din0   = r_din;
    assign busy        = r_busy;

endmodule

// File: tb/tb_wb_sram_port0_ctrl.sv
// Bench for wb_sram_port0_ctrl with a behavioural SRAM (2-cycle read latency) and queue-based monitors;
// aux expectations follow SRAM_CTRL_AUX_EN.
module tb_wb_sram_port0_ctrl;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        wb_rst_i;
    logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i, wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        aux_req, aux_we;
    logic [7:0]  aux_addr;
    logic [31:0] aux_wdata;
    logic [3:0]  aux_wmask;
    logic        aux_gnt, aux_rvalid;
    logic [31:0] aux_rdata;
    logic        sram_csb0, sram_web0;
    logic [3:0]  sram_wmask0;
    logic [7:0]  sram_addr0;
    logic [31:0] sram_din0;
    logic [31:0] sram_dout0;
    logic        busy;

    wb_sram_port0_ctrl #(
        .BASE_ADDR(32'h3000_0000),
        .WIN_BITS (10),
        .READ_LAT (LAT)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (wb_rst_i),
        .wbs_cyc_i  (wbs_cyc_i),
        .wbs_stb_i  (wbs_stb_i),
        .wbs_we_i   (wbs_we_i),
        .wbs_sel_i  (wbs_sel_i),
        .wbs_adr_i  (wbs_adr_i),
        .wbs_dat_i  (wbs_dat_i),
        .wbs_ack_o  (wbs_ack_o),
        .wbs_dat_o  (wbs_dat_o),
        .aux_req    (aux_req),
        .aux_we     (aux_we),
        .aux_addr   (aux_addr),
        .aux_wdata  (aux_wdata),
        .aux_wmask  (aux_wmask),
        .aux_gnt    (aux_gnt),
        .aux_rvalid (aux_rvalid),
        .aux_rdata  (aux_rdata),
        .sram_csb0  (sram_csb0),
        .sram_web0  (sram_web0),
        .sram_wmask0(sram_wmask0),
        .sram_addr0 (sram_addr0),
        .sram_din0  (sram_din0),
        .sram_dout0 (sram_dout0),
        .busy       (busy)
    );

    // ---------------- clock / reset / edge counter ----------------
    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion earlier");
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural SRAM: dout valid two edges after capture ----------------
    logic [31:0] mem [0:255];
    logic [31:0] rd_stage = 32'h0;
    logic [31:0] m_word;
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        sram_dout0 = 32'h0;
    end
    always @(posedge clk) begin
        if (sram_csb0 === 1'b0) begin
            if (sram_web0 === 1'b0) begin
                m_word = mem[sram_addr0];
                for (int b = 0; b < 4; b++)
                    if (sram_wmask0[b]) m_word[8*b +: 8] = sram_din0[8*b +: 8];
                mem[sram_addr0] <= m_word;
            end else begin
                rd_stage <= mem[sram_addr0];
            end
        end
        sram_dout0 <= rd_stage;
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] dat;
        int          at_edge;
    } rsp_t;
    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [3:0]  mask;
        logic [31:0] din;
    } acc_t;

    rsp_t wb_q[$];
    rsp_t rv_q[$];
    int   gnt_q[$];
    acc_t sram_q[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: event occurrence got 1 required 0 (t=%0t)", name, $time);
    endtask

    task automatic exp_acc(input logic we, input logic [7:0] addr, input logic [3:0] mask,
                           input logic [31:0] din);
        sram_q.push_back('{we: we, addr: addr, mask: mask, din: din});
    endtask

    // ---------------- monitors (sample on the falling edge) ----------------
    logic prev_low = 1'b0;
    always @(negedge clk) begin
        rsp_t r;
        acc_t a;
        if (wbs_ack_o === 1'b1) begin
            if (wb_q.size() == 0) fail("wb_ack_unexpected");
            else begin
                r = wb_q.pop_front();
                chk("wb_ack_edge", edge_cnt + 1, r.at_edge);
                chk("wb_dat", wbs_dat_o, r.dat);
            end
        end
        if (sram_csb0 === 1'b0) begin
            if (prev_low) fail("csb0_width");
            if (sram_q.size() == 0) fail("sram_access_unexpected");
            else begin
                a = sram_q.pop_front();
                chk("sram_web0", sram_web0, !a.we);
                chk("sram_addr0", sram_addr0, a.addr);
                if (a.we) begin
                    chk("sram_wmask0", sram_wmask0, a.mask);
                    chk("sram_din0", sram_din0, a.din);
                end
            end
        end
        prev_low = (sram_csb0 === 1'b0);
`ifdef SRAM_CTRL_AUX_EN
        if (aux_gnt === 1'b1) begin
            if (gnt_q.size() == 0) fail("aux_gnt_unexpected");
            else chk("aux_gnt_edge", edge_cnt + 1, gnt_q.pop_front());
        end
        if (aux_rvalid === 1'b1) begin
            if (rv_q.size() == 0) fail("aux_rvalid_unexpected");
            else begin
                r = rv_q.pop_front();
                chk("aux_rvalid_edge", edge_cnt + 1, r.at_edge);
                chk("aux_rdata", aux_rdata, r.dat);
            end
        end
`else
        if (aux_gnt !== 1'b0 || aux_rvalid !== 1'b0 || aux_rdata !== 32'h0) fail("aux_tied_zero");
`endif
    end

    // ---------------- drivers ----------------
    task automatic wb_start(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                            input logic [31:0] dat, input logic ack_exp,
                            input logic [31:0] exp_dat, input int lat);
        @(negedge clk);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = we;
        wbs_adr_i = adr;
        wbs_sel_i = sel;
        wbs_dat_i = dat;
        if (ack_exp) wb_q.push_back('{dat: exp_dat, at_edge: edge_cnt + 1 + lat});
    endtask

    task automatic wb_drop();
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
    endtask

    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                           input logic [31:0] dat, input logic [31:0] exp_dat, input int lat);
        bit got = 0;
        wb_start(we, adr, sel, dat, 1'b1, exp_dat, lat);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (wbs_ack_o === 1'b1) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL wb_ack_timeout: got no ack required ack at edge %0d", edge_cnt);
        end
        wb_drop();
    endtask

    task automatic aux_xfer(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wmask, input int gnt_lat, input logic rv_exp,
                            input logic [31:0] rv_dat, input int rv_lat);
        @(negedge clk);
        aux_req   = 1'b1;
        aux_we    = we;
        aux_addr  = addr;
        aux_wdata = wdata;
        aux_wmask = wmask;
`ifdef SRAM_CTRL_AUX_EN
        begin
            bit got = 0;
            gnt_q.push_back(edge_cnt + 1 + gnt_lat);
            if (rv_exp) rv_q.push_back('{dat: rv_dat, at_edge: edge_cnt + 1 + rv_lat});
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (aux_gnt === 1'b1) begin
                    got = 1;
                    break;
                end
            end
            if (!got) begin
                n_vec++;
                n_err++;
                $display("FAIL aux_gnt_timeout: got no grant required grant at edge %0d", edge_cnt);
            end
        end
`else
        repeat (12) @(negedge clk);
`endif
        aux_req = 1'b0;
        aux_we  = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_csb0"},   sram_csb0,   1'b1);
        chk({tag, "_web0"},   sram_web0,   1'b1);
        chk({tag, "_wmask0"}, sram_wmask0, 4'h0);
        chk({tag, "_addr0"},  sram_addr0,  8'h0);
        chk({tag, "_din0"},   sram_din0,   32'h0);
        chk({tag, "_ack"},    wbs_ack_o,   1'b0);
        chk({tag, "_dat"},    wbs_dat_o,   32'h0);
        chk({tag, "_gnt"},    aux_gnt,     1'b0);
        chk({tag, "_rvalid"}, aux_rvalid,  1'b0);
        chk({tag, "_rdata"},  aux_rdata,   32'h0);
        chk({tag, "_busy"},   busy,        1'b0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        wb_rst_i  = 1'b1;
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        wbs_sel_i = 4'h0;
        wbs_adr_i = 32'h0;
        wbs_dat_i = 32'h0;
        aux_req   = 1'b0;
        aux_we    = 1'b0;
        aux_addr  = 8'h0;
        aux_wdata = 32'h0;
        aux_wmask = 4'h0;
        repeat (3) @(negedge clk);
        check_reset_vals("rst0");
        wb_rst_i = 1'b0;

        // full-word write, read back, partial write, read back
        exp_acc(1'b1, 8'h04, 4'hF, 32'hDEAD_BEEF);
        wb_xfer(1'b1, 32'h3000_0010, 4'hF, 32'hDEAD_BEEF, 32'h0, 2);
        exp_acc(1'b0, 8'h04, 4'hF, 32'h0);
        wb_xfer(1'b0, 32'h3000_0010, 4'hF, 32'h0, 32'hDEAD_BEEF, 2 + LAT);
        exp_acc(1'b1, 8'h04, 4'b0010, 32'h0000_AB00);
        wb_xfer(1'b1, 32'h3000_0010, 4'b0010, 32'h0000_AB00, 32'hDEAD_BEEF, 2);
        exp_acc(1'b0, 8'h04, 4'hF, 32'h0);
        wb_xfer(1'b0, 32'h3000_0010, 4'hF, 32'h0, 32'hDEAD_ABEF, 2 + LAT);

        // window misses: ack one edge later with zero data and no SRAM strobe
        wb_xfer(1'b0, 32'h2000_0000, 4'hF, 32'h0, 32'h0, 1);
        wb_xfer(1'b1, 32'h2000_0004, 4'hF, 32'h5555_5555, 32'h0, 1);

        @(negedge clk);
        wb_rst_i = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_vals("rst1");
        wb_rst_i = 1'b0;

        // simultaneous requests after reset; WB re-requests while aux still waits
`ifdef SRAM_CTRL_AUX_EN
        exp_acc(1'b0, 8'h04, 4'hF, 32'h0);
        exp_acc(1'b0, 8'h04, 4'hF, 32'h0);
        exp_acc(1'b0, 8'h04, 4'hF, 32'h0);
        fork
            begin
                wb_xfer(1'b0, 32'h3000_0010, 4'hF, 32'h0, 32'hDEAD_ABEF, 4);
                wb_xfer(1'b0, 32'h3000_0010, 4'hF, 32'h0, 32'hDEAD_ABEF, 9);
            end
            aux_xfer(1'b0, 8'h04, 32'h0, 4'hF, 6, 1'b1, 32'hDEAD_ABEF, 9);
        join
        // fresh pair with WB as last owner: aux write lands before the WB read
        exp_acc(1'b1, 8'h05, 4'hF, 32'h1234_5678);
        exp_acc(1'b0, 8'h05, 4'hF, 32'h0);
        fork
            wb_xfer(1'b0, 32'h3000_0014, 4'hF, 32'h0, 32'h1234_5678, 7);
            aux_xfer(1'b1, 8'h05, 32'h1234_5678, 4'hF, 1, 1'b0, 32'h0, 0);
        join
`else
        exp_acc(1'b0, 8'h04, 4'hF, 32'h0);
        exp_acc(1'b0, 8'h04, 4'hF, 32'h0);
        fork
            begin
                wb_xfer(1'b0, 32'h3000_0010, 4'hF, 32'h0, 32'hDEAD_ABEF, 4);
                wb_xfer(1'b0, 32'h3000_0010, 4'hF, 32'h0, 32'hDEAD_ABEF, 4);
            end
            aux_xfer(1'b0, 8'h04, 32'h0, 4'hF, 6, 1'b1, 32'hDEAD_ABEF, 9);
        join
        exp_acc(1'b0, 8'h05, 4'hF, 32'h0);
        fork
            wb_xfer(1'b0, 32'h3000_0014, 4'hF, 32'h0, 32'h0, 4);
            aux_xfer(1'b1, 8'h05, 32'h1234_5678, 4'hF, 1, 1'b0, 32'h0, 0);
        join
`endif

        // abort by dropping cyc in WAIT: access completes, ack withheld
        exp_acc(1'b0, 8'h04, 4'hF, 32'h0);
        wb_start(1'b0, 32'h3000_0010, 4'hF, 32'h0, 1'b0, 32'h0, 0);
        repeat (2) @(negedge clk);
        chk("abort_busy_wait", busy, 1'b1);
        wb_drop();
        repeat (6) @(negedge clk);
        chk("abort_busy_idle", busy, 1'b0);
`ifdef SRAM_CTRL_AUX_EN
        exp_acc(1'b0, 8'h05, 4'hF, 32'h0);
        wb_xfer(1'b0, 32'h3000_0014, 4'hF, 32'h0, 32'h1234_5678, 2 + LAT);
`else
        exp_acc(1'b0, 8'h05, 4'hF, 32'h0);
        wb_xfer(1'b0, 32'h3000_0014, 4'hF, 32'h0, 32'h0, 2 + LAT);
`endif

        // reset in WAIT: everything back to reset values, no ack afterwards
        exp_acc(1'b0, 8'h04, 4'hF, 32'h0);
        wb_start(1'b0, 32'h3000_0010, 4'hF, 32'h0, 1'b0, 32'h0, 0);
        repeat (2) @(negedge clk);
        wb_rst_i = 1'b1;
        @(negedge clk);
        check_reset_vals("rst_wait");
        wb_rst_i = 1'b0;
        wb_drop();
        repeat (6) @(negedge clk);

        exp_acc(1'b1, 8'h06, 4'hF, 32'hCAFE_F00D);
        wb_xfer(1'b1, 32'h3000_0018, 4'hF, 32'hCAFE_F00D, 32'h0, 2);
        exp_acc(1'b0, 8'h06, 4'hF, 32'h0);
        wb_xfer(1'b0, 32'h3000_0018, 4'hF, 32'h0, 32'hCAFE_F00D, 2 + LAT);

        repeat (10) @(negedge clk);
        chk("wb_q_left", wb_q.size(), 0);
        chk("sram_q_left", sram_q.size(), 0);
        chk("gnt_q_left", gnt_q.size(), 0);
        chk("rv_q_left", rv_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wb_sram_port0_ctrl.md
Name: wb_sram_port0_ctrl

Overview:
Controller for port 0 (read/write) of the sky130_sram_1kbyte_1rw1r_32x256_8 macro (256 x 32-bit words, 4-bit byte write mask).
- Turns Wishbone classic slave cycles into correctly timed active-low csb0/web0 strobes.
- Waits out the macro read latency and generates a single-cycle ack.
- Shares port 0 round-robin with an auxiliary streaming requester (for example an RX engine).
- Sits in user_project_wrapper, between the Wishbone slave bus and the SRAM macro instance.

Parameters:
BASE_ADDR, 32'h3000_0000, Wishbone byte-address base of the SRAM window.
WIN_BITS, 10, window size in address bits; decode compares wbs_adr_i[31:WIN_BITS] with BASE_ADDR[31:WIN_BITS].
READ_LAT, 1, cycles from the macro capture edge to valid dout0 (range 1..3).

Ports:
wb_clk_i  in  1  single clock for the block and the macro.
wb_rst_i  in  1  reset, synchronous, active-high.
wbs_cyc_i  in  1  Wishbone cycle.
wbs_stb_i  in  1  Wishbone strobe.
wbs_we_i  in  1  Wishbone write enable.
wbs_sel_i  in  4  byte selects.
wbs_adr_i  in  32  byte address.
wbs_dat_i  in  32  write data.
wbs_ack_o  out  1  ack, one-cycle pulse.
wbs_dat_o  out  32  read data, registered.
aux_req  in  1  aux request, held until aux_gnt.
aux_we  in  1  aux write.
aux_addr  in  8  aux word address.
aux_wdata  in  32  aux write data.
aux_wmask  in  4  aux byte mask.
aux_gnt  out  1  one-cycle accept pulse.
aux_rvalid  out  1  one-cycle read-data-valid pulse.
aux_rdata  out  32  aux read data.
sram_csb0  out  1  macro chip select, active low.
sram_web0  out  1  macro write enable, active low.
sram_wmask0  out  4  macro byte mask.
sram_addr0  out  8  macro word address.
sram_din0  out  32  macro write data.
sram_dout0  in  32  macro read data.
busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Clock and reset: single clock wb_clk_i; reset wb_rst_i is synchronous and active-high.
- All outputs are registered.
- Reset values:
  - sram_csb0=1, sram_web0=1; sram_wmask0, sram_addr0, sram_din0 = 0.
  - wbs_ack_o=0, wbs_dat_o=0; aux_gnt, aux_rvalid, aux_rdata = 0; busy=0.
  - FSM in IDLE; last_owner=AUX, so Wishbone wins the first tie.
- Wishbone request = wbs_cyc_i & wbs_stb_i & window hit.
- Word address = wbs_adr_i[9:2]; wmask = wbs_sel_i.
- FSM states: IDLE, ISSUE, WAIT, ACK, MISS.
- IDLE:
  - Selects a winner. With both requesting, the grant goes to the requester that is not last_owner; otherwise the sole requester wins.
  - On a grant: registers sram_addr0, sram_din0, sram_wmask0; sets sram_csb0=0 and sram_web0=~we; pulses aux_gnt if aux won; updates last_owner; goes to ISSUE.
  - cyc&stb with a window miss and no grant: goes to MISS.
- ISSUE:
  - The macro captures on this edge.
  - sram_csb0 and sram_web0 return to 1 at the end of ISSUE; csb0 is low for exactly one cycle per access.
  - Write: go to ACK. Read: go to WAIT with count = READ_LAT.
- WAIT:
  - Decrements the count.
  - At count==1: captures sram_dout0 into wbs_dat_o (Wishbone owner) or aux_rdata (aux owner), then goes to ACK.
- ACK:
  - Wishbone owner: wbs_ack_o=1 for one cycle, and only if wbs_cyc_i is still high. An aborted cycle completes in the SRAM but the ack is suppressed.
  - Aux owner: aux_rvalid=1 for one cycle on reads only; writes produce no response beyond aux_gnt.
  - Then go to IDLE.
- MISS: wbs_ack_o=1 and wbs_dat_o=0 for one cycle, with no SRAM access; then IDLE.
- Latency, with request sampled in IDLE at cycle N:
  - write ack at N+2;
  - read ack at N+2+READ_LAT;
  - miss ack at N+1.
- Back-to-back: a stb still high in IDLE after an ack is treated as a new transaction. Throughput is one write per 3 cycles.
- wbs_dat_o holds its value until the next Wishbone read or miss.
- A synchronous reset asserted in any state forces the reset values on the next edge. No ack or rvalid is issued for the interrupted access.

Optional Feature:
Macro SRAM_CTRL_AUX_EN.
- Defined: aux port and round-robin arbitration are present as described.
- Undefined:
  - aux_* inputs are ignored; aux_gnt, aux_rvalid, aux_rdata are tied 0.
  - Wishbone always wins and the last_owner register is removed.
  - Wishbone timing is identical to the defined case.

Test Plan:
1. Reset, then a Wishbone write to 0x3000_0010, data 0xDEADBEEF, sel=4'hF -> one csb0 low pulse with addr0=0x04, web0=0, wmask0=0xF; ack at N+2.
2. Wishbone read of 0x3000_0010 with READ_LAT=2 -> ack at N+4 with wbs_dat_o=0xDEADBEEF; csb0 low exactly one cycle.
3. Write with sel=4'b0010, data 0x0000AB00, then read back -> 0xDEADABEF.
4. Wishbone read and aux_req (read, addr 0x04) asserted in the same cycle after reset:
   - Wishbone is served first; aux_gnt follows the Wishbone ack in the next IDLE.
   - aux_rvalid fires with aux_rdata=0xDEADABEF.
   - A second simultaneous pair is served aux first.
5. Access to 0x2000_0000 -> ack at N+1 with wbs_dat_o=0; csb0 stays 1.
6. Both abort cases:
   - Drop wbs_cyc_i during WAIT -> no ack; next request is accepted normally.
   - Assert wb_rst_i during WAIT -> all outputs return to reset values and no ack or rvalid is issued.
